// File: rtl/decode_pkg.sv
// Instruction-set package shared by the decode stage and its scoreboard:
// opcode constants and per-opcode operand/destination helpers.
package decode_pkg;

  localparam int OPW = 6;

  localparam logic [OPW-1:0] INST_SW   = 6'b000000;
  localparam logic [OPW-1:0] INST_ADD  = 6'b000001;
  localparam logic [OPW-1:0] INST_J    = 6'b000010;
  localparam logic [OPW-1:0] INST_ADDI = 6'b000011;
  localparam logic [OPW-1:0] INST_LW   = 6'b000100;
  localparam logic [OPW-1:0] INST_BEQ  = 6'b000101;
  localparam logic [OPW-1:0] INST_BNE  = 6'b000110;
  localparam logic [OPW-1:0] INST_LUI  = 6'b001000;
  localparam logic [OPW-1:0] INST_FSW  = 6'b010000;
  localparam logic [OPW-1:0] INST_FMVI = 6'b010001;
  localparam logic [OPW-1:0] INST_FADD = 6'b011000;
  localparam logic [OPW-1:0] INST_FEQ  = 6'b011001;

  function automatic logic is_branch_inst(input logic [OPW-1:0] op);
    return (op == INST_BEQ) || (op == INST_BNE);
  endfunction

  function automatic logic uses_src1(input logic [OPW-1:0] op);
    return op inside {INST_SW, INST_ADD, INST_ADDI, INST_LW,
                      INST_BEQ, INST_BNE, INST_FSW, INST_FMVI,
                      INST_FADD, INST_FEQ};
  endfunction

  function automatic logic uses_src2(input logic [OPW-1:0] op);
    return op inside {INST_SW, INST_ADD, INST_BEQ, INST_BNE,
                      INST_FSW, INST_FADD, INST_FEQ};
  endfunction

  function automatic logic writes_rd(input logic [OPW-1:0] op);
    return op inside {INST_ADD, INST_ADDI, INST_LW, INST_LUI,
                      INST_FMVI, INST_FADD, INST_FEQ};
  endfunction

  // Float compares land in the integer file.
  function automatic logic fmode_dest(input logic [OPW-1:0] op);
    return op[4] && (op != INST_FEQ);
  endfunction

  function automatic logic src1_fmode(input logic [31:0] cmd);
    return cmd[30] && (cmd[29:27] != 3'b000);
  endfunction

  function automatic logic src2_fmode(input logic [31:0] cmd);
    return cmd[30] && (cmd[29:26] != 4'b0001);
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Busy bits for the integer and float register files with
// set/clear/flush-undo precedence and the read-port hazard lookup.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int REGW = 5,
  parameter int NREG = 2**REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic            set_f,
  input  logic [REGW-1:0] set_no,
  input  logic            clr_en,
  input  logic            clr_f,
  input  logic [REGW-1:0] clr_no,
  input  logic            undo_en,
  input  logic            undo_f,
  input  logic [REGW-1:0] undo_no,
  input  logic            use1,
  input  logic            f1,
  input  logic [REGW-1:0] no1,
  input  logic            use2,
  input  logic            f2,
  input  logic [REGW-1:0] no2,
  output logic            hazard1,
  output logic            hazard2
);

  logic [1:0][NREG-1:0] busy;
  logic [1:0][NREG-1:0] busy_nxt;
  logic                 clr1;
  logic                 clr2;

  // A writeback landing this cycle already satisfies the read.
  assign clr1 = clr_en && (clr_f == f1) && (clr_no == no1);
  assign clr2 = clr_en && (clr_f == f2) && (clr_no == no2);

  assign hazard1 = use1 && busy[f1][no1] && !clr1;
  assign hazard2 = use2 && busy[f2][no2] && !clr2;

  always_comb begin
    busy_nxt = busy;
    if (clr_en)
      busy_nxt[clr_f][clr_no] = 1'b0;
    if (undo_en)
      busy_nxt[undo_f][undo_no] = 1'b0;
    if (set_en && (set_f || (set_no != '0)))
      busy_nxt[set_f][set_no] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: rtl/decode_stage.sv
// Fetch-to-execute decode stage: field extraction, handshakes,
// operand capture with writeback forwarding and a stall counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_command,
  input  logic            flush,
  output logic            fmode1,
  output logic            fmode2,
  output logic [REGW-1:0] reg1,
  output logic [REGW-1:0] reg2,
  input  logic [XLEN-1:0] reg_out1,
  input  logic [XLEN-1:0] reg_out2,
  input  logic            wb_valid,
  input  logic            wb_fmode,
  input  logic [REGW-1:0] wb_no,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      opecode,
  output logic [15:0]     offset,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs,
  output logic [XLEN-1:0] rt,
  output logic [REGW-1:0] rd_no,
  output logic [REGW-1:0] rs_no,
  output logic [REGW-1:0] rt_no,
  output logic            fmode1_reg,
  output logic            fmode2_reg,
  output logic [CNTW-1:0] stall_cnt
);

  logic [OPW-1:0]  op;
  logic [REGW-1:0] dest;
  logic            fdest;
  logic            hz1;
  logic            hz2;
  logic            hazard;
  logic            accept;
  logic            fwd1;
  logic            fwd2;
  logic            held_sets_busy;
  logic            held_f;
  logic [REGW-1:0] held_rd;

  assign op     = in_command[31:26];
  assign dest   = in_command[21 +: REGW];
  assign fdest  = fmode_dest(op);
  assign reg1   = in_command[16 +: REGW];
  assign reg2   = ((in_command[29:26] == 4'b0000) || is_branch_inst(op))
                ? in_command[21 +: REGW] : in_command[11 +: REGW];
  assign fmode1 = src1_fmode(in_command);
  assign fmode2 = src2_fmode(in_command);

  decode_scoreboard #(
    .REGW (REGW),
    .NREG (NREG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (accept && writes_rd(op)),
    .set_f   (fdest),
    .set_no  (dest),
    .clr_en  (wb_valid),
    .clr_f   (wb_fmode),
    .clr_no  (wb_no),
    .undo_en (flush && held_sets_busy),
    .undo_f  (held_f),
    .undo_no (held_rd),
    .use1    (uses_src1(op)),
    .f1      (fmode1),
    .no1     (reg1),
    .use2    (uses_src2(op)),
    .f2      (fmode2),
    .no2     (reg2),
    .hazard1 (hz1),
    .hazard2 (hz2)
  );

  assign hazard   = in_valid && (hz1 || hz2);
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign fwd1 = wb_valid && (wb_fmode == fmode1) && (wb_no == reg1);
  assign fwd2 = wb_valid && (wb_fmode == fmode2) && (wb_no == reg2);

  always_ff @(posedge clk) begin
    if (rst) begin
      opecode        <= INST_J;
      offset         <= '0;
      pc_out         <= '0;
      rs             <= '0;
      rt             <= '0;
      rd_no          <= '0;
      rs_no          <= '0;
      rt_no          <= '0;
      fmode1_reg     <= 1'b0;
      fmode2_reg     <= 1'b0;
      out_valid      <= 1'b0;
      held_sets_busy <= 1'b0;
      held_f         <= 1'b0;
      held_rd        <= '0;
      stall_cnt      <= '0;
    end else begin
      if (accept) begin
        opecode        <= op;
        offset         <= in_command[15:0];
        pc_out         <= in_pc;
        rs             <= fwd1 ? wb_data : reg_out1;
        rt             <= fwd2 ? wb_data : reg_out2;
        rd_no          <= dest;
        rs_no          <= reg1;
        rt_no          <= reg2;
        fmode1_reg     <= fmode1;
        fmode2_reg     <= fmode2;
        out_valid      <= 1'b1;
        held_sets_busy <= writes_rd(op);
        held_f         <= fdest;
        held_rd        <= dest;
      end else if (flush || (out_valid && out_ready)) begin
        out_valid      <= 1'b0;
        held_sets_busy <= 1'b0;
      end
      if (hazard && !flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios then random
// traffic checked against a register-level reference model.
`timescale 1ns/1ps
module tb_decode_stage;
  import decode_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REGW = 5;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0;
  logic [31:0]     in_command = '0;
  logic            flush = 1'b0;
  logic            fmode1, fmode2;
  logic [REGW-1:0] reg1, reg2;
  logic [XLEN-1:0] reg_out1, reg_out2;
  logic            wb_valid = 1'b0;
  logic            wb_fmode = 1'b0;
  logic [REGW-1:0] wb_no = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [5:0]      opecode;
  logic [15:0]     offset;
  logic [XLEN-1:0] pc_out, rs, rt;
  logic [REGW-1:0] rd_no, rs_no, rt_no;
  logic            fmode1_reg, fmode2_reg;
  logic [CNTW-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN(XLEN), .NREG(NREG), .REGW(REGW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_command(in_command), .flush(flush),
    .fmode1(fmode1), .fmode2(fmode2), .reg1(reg1), .reg2(reg2),
    .reg_out1(reg_out1), .reg_out2(reg_out2),
    .wb_valid(wb_valid), .wb_fmode(wb_fmode),
    .wb_no(wb_no), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opecode(opecode), .offset(offset), .pc_out(pc_out),
    .rs(rs), .rt(rt), .rd_no(rd_no), .rs_no(rs_no), .rt_no(rt_no),
    .fmode1_reg(fmode1_reg), .fmode2_reg(fmode2_reg),
    .stall_cnt(stall_cnt)
  );

  // Behavioural register files answering the read ports
  logic [XLEN-1:0] rf [2][NREG];
  assign reg_out1 = rf[fmode1][reg1];
  assign reg_out2 = rf[fmode2][reg2];

  typedef struct {
    logic [5:0]      op;
    logic [15:0]     off;
    logic [XLEN-1:0] pc, a, b;
    logic [REGW-1:0] rd, r1, r2;
    logic            f1, f2;
  } exp_t;

  exp_t q[$];
  bit   busy [2][NREG];
  bit   m_ov, m_hb, m_hf;
  logic [REGW-1:0] m_hrd;
  int   m_stall;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op,
      input logic [4:0] rd, input logic [4:0] s1,
      input logic [4:0] s2, input logic [10:0] imm);
    return {op, rd, s1, s2, imm};
  endfunction

  task automatic cyc(input bit v, input logic [31:0] cmd,
      input logic [XLEN-1:0] pc, input bit fl, input bit ordy,
      input bit wv, input bit wf, input logic [REGW-1:0] wn,
      input logic [XLEN-1:0] wd);
    logic [5:0]      op;
    logic [REGW-1:0] r1, r2, rdn;
    bit f1, f2, fd, u1, u2, w, c1, c2, hz, rdy, acc;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_command = cmd; in_pc = pc; flush = fl;
    out_ready = fl ? 1'b0 : ordy;
    wb_valid = wv; wb_fmode = wf; wb_no = wn; wb_data = wd;
    #2;
    op  = cmd[31:26];
    r1  = cmd[20:16];
    rdn = cmd[25:21];
    r2  = (cmd[29:26] == 0 || op == INST_BEQ || op == INST_BNE)
        ? cmd[25:21] : cmd[15:11];
    f1  = cmd[30] && (cmd[29:27] != 0);
    f2  = cmd[30] && (cmd[29:26] != 1);
    u1  = !(op inside {INST_J, INST_LUI});
    u2  = op inside {INST_SW, INST_ADD, INST_BEQ, INST_BNE,
                     INST_FSW, INST_FADD, INST_FEQ};
    w   = op inside {INST_ADD, INST_ADDI, INST_LW, INST_LUI,
                     INST_FMVI, INST_FADD, INST_FEQ};
    fd  = (op == INST_FMVI) || (op == INST_FADD);
    c1  = wv && wf == f1 && wn == r1;
    c2  = wv && wf == f2 && wn == r2;
    hz  = v && ((u1 && busy[f1][r1] && !c1) || (u2 && busy[f2][r2] && !c2));
    rdy = !hz && (!m_ov || out_ready) && !fl;
    acc = v && rdy;
    chk("in_ready", in_ready, rdy);
    chk("reg1", reg1, r1);
    chk("reg2", reg2, r2);
    chk("fmode1", fmode1, f1);
    chk("fmode2", fmode2, f2);
    chk("stall_cnt", stall_cnt, m_stall);
    if (acc) begin
      e.op = op; e.off = cmd[15:0]; e.pc = pc;
      e.a = c1 ? wd : rf[f1][r1];
      e.b = c2 ? wd : rf[f2][r2];
      e.rd = rdn; e.r1 = r1; e.r2 = r2; e.f1 = f1; e.f2 = f2;
      q.push_back(e);
    end
    if (fl && m_ov && q.size() > 0)
      void'(q.pop_front());
    @(posedge clk);
    #1;
    if (wv) begin
      busy[wf][wn] = 1'b0;
      rf[wf][wn] = wd;
    end
    if (fl && m_hb) busy[m_hf][m_hrd] = 1'b0;
    if (acc && w && (fd || rdn != 0)) busy[fd][rdn] = 1'b1;
    if (hz && !fl && m_stall != 16'hFFFF) m_stall++;
    if (fl) begin
      m_ov = 1'b0; m_hb = 1'b0;
    end else if (acc) begin
      m_ov = 1'b1; m_hb = w; m_hf = fd; m_hrd = rdn;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0; m_hb = 1'b0;
    end
  endtask

  task automatic idle(input bit ordy);
    cyc(0, 32'h0, '0, 0, ordy, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b0; wb_valid = 1'b0;
    @(posedge clk);
    #1;
    foreach (busy[i, j]) busy[i][j] = 1'b0;
    m_ov = 1'b0; m_hb = 1'b0; m_stall = 0;
    q.delete();
    @(negedge clk);
    #1;
    chk("rst_opecode", opecode, INST_J);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, '0);
    chk("rst_pc_out", pc_out, '0);
    chk("rst_rs", rs, '0);
    rst = 1'b0;
  endtask

  // Monitor: compare each consumed output against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        chk("out_valid", out_valid, m_ov);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got output pc %0h, expected none",
                     pc_out);
          end else begin
            e = q.pop_front();
            chk("opecode", opecode, e.op);
            chk("offset", offset, e.off);
            chk("pc_out", pc_out, e.pc);
            chk("rs", rs, e.a);
            chk("rt", rt, e.b);
            chk("rd_no", rd_no, e.rd);
            chk("rs_no", rs_no, e.r1);
            chk("rt_no", rt_no, e.r2);
            chk("fmode1_reg", fmode1_reg, e.f1);
            chk("fmode2_reg", fmode2_reg, e.f2);
          end
        end
      end
    end
  end

  logic [5:0] ops [12];

  initial begin
    foreach (rf[i, j]) rf[i][j] = XLEN'($urandom);
    rf[0][1] = 5;
    rf[0][2] = 7;
    ops = '{INST_SW, INST_ADD, INST_J, INST_ADDI, INST_LW, INST_BEQ,
            INST_BNE, INST_LUI, INST_FSW, INST_FMVI, INST_FADD, INST_FEQ};
    do_reset();

    // single ALU op
    cyc(1, enc(INST_ADD, 10, 1, 2, 0), 'h100, 0, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 1, 0, 10, 'h11);

    // RAW stall on r3, released by same-cycle writeback
    cyc(1, enc(INST_ADDI, 3, 1, 0, 4), 'h104, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, enc(INST_ADD, 5, 3, 2, 0), 'h108, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_ADD, 5, 3, 2, 0), 'h108, 0, 1, 1, 0, 3, 'h2A);
    idle(1);
    chk("stall_three", stall_cnt, 3);
    cyc(0, 0, 0, 0, 1, 1, 0, 5, 'h55);

    // back-pressure then back-to-back
    cyc(1, enc(INST_LUI, 0, 0, 0, 1), 'h200, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, enc(INST_J, 0, 0, 0, 2), 'h204, 0, 0, 0, 0, 0, 0);
    cyc(1, enc(INST_J, 0, 0, 0, 2), 'h204, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_J, 0, 0, 0, 3), 'h208, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_SW, 2, 1, 0, 4), 'h20C, 0, 1, 0, 0, 0, 0);
    idle(1);

    // float f4 busy, int r4 independent
    cyc(1, enc(INST_FMVI, 4, 1, 0, 0), 'h300, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_ADD, 12, 4, 4, 0), 'h304, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_FADD, 13, 4, 4, 0), 'h308, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_FADD, 13, 4, 4, 0), 'h308, 0, 1, 1, 1, 4, 'h3F80);
    idle(1);
    cyc(0, 0, 0, 0, 1, 1, 0, 12, 1);
    cyc(0, 0, 0, 0, 1, 1, 1, 13, 2);

    // flush undoes held writer of r6
    cyc(1, enc(INST_LUI, 6, 0, 0, 9), 'h400, 0, 0, 0, 0, 0, 0);
    cyc(1, enc(INST_ADD, 7, 6, 0, 0), 'h404, 1, 0, 0, 0, 0, 0);
    cyc(1, enc(INST_ADD, 7, 6, 0, 0), 'h408, 0, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 1, 0, 7, 3);

    // reset clears busy bits
    cyc(1, enc(INST_LUI, 11, 0, 0, 1), 'h500, 0, 1, 0, 0, 0, 0);
    do_reset();
    cyc(1, enc(INST_ADD, 14, 11, 0, 0), 'h504, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 14, 4);

    // r0 never busy; set beats same-cycle clear on r9
    cyc(1, enc(INST_LUI, 0, 0, 0, 1), 'h600, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_ADD, 15, 0, 0, 0), 'h604, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_LUI, 9, 0, 0, 1), 'h608, 0, 1, 1, 0, 9, 'h99);
    cyc(1, enc(INST_ADD, 16, 9, 0, 0), 'h60C, 0, 1, 0, 0, 0, 0);
    cyc(1, enc(INST_ADD, 16, 9, 0, 0), 'h60C, 0, 1, 1, 0, 9, 'h77);
    idle(1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] c;
      bit fl, wv;
      c = enc(ops[$urandom_range(11)], 5'($urandom_range(7)),
              5'($urandom_range(7)), 5'($urandom_range(7)),
              11'($urandom));
      fl = ($urandom_range(99) < 4);
      wv = ($urandom_range(99) < 35);
      cyc($urandom_range(99) < 80, c, XLEN'($urandom), fl,
          $urandom_range(99) < 75, wv, 1'($urandom),
          REGW'($urandom_range(7)), XLEN'($urandom));
    end
    repeat (4) idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor of the single-register decode latch: fetch-to-execute decode stage with valid/ready handshakes on both sides, a flush input, and a per-register-file scoreboard.
- Scoreboard stalls on read-after-write hazards; captured operands are forwarded from a same-cycle writeback.
- Sits between fetch and execute; drives the register-file read ports combinationally and reports stall cycles for performance counters.

Parameters:
- XLEN, 32, data/PC width
- NREG, 32, registers per file (integer and float)
- REGW, 5, register index width; NREG = 2**REGW
- CNTW, 16, width of saturating stall counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch offers command
- in_ready  out  1  stage accepts command this cycle
- in_pc  in  XLEN  PC of offered command
- in_command  in  32  instruction word
- flush  in  1  kill held and offered instruction
- fmode1, fmode2  out  1 each  register-file select for read ports (1 = float)
- reg1, reg2  out  REGW each  read port indices
- reg_out1, reg_out2  in  XLEN each  read data, combinational
- wb_valid  in  1  writeback this cycle
- wb_fmode  in  1  writeback file
- wb_no  in  REGW  writeback register
- wb_data  in  XLEN  writeback value
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute consumes
- opecode  out  6;  offset  out  16;  pc_out  out  XLEN
- rs, rt  out  XLEN each  operand values
- rd_no, rs_no, rt_no  out  REGW each
- fmode1_reg, fmode2_reg  out  1 each
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles

Behaviour:
- Field extraction, combinational from in_command:
  - reg1 = [20:16]
  - reg2 = [25:21] if [29:26]==0 or is_branch_inst([31:26]), else [15:11]
  - fmode1 = [30] && [29:27]!=0
  - fmode2 = [30] && [29:26]!=4'b0001
  - destination index = [25:21]
- Hazard: rd1 = src1_used && busy[fmode1][reg1]; rd2 likewise for port 2; hazard = in_valid && (rd1 || rd2).
  - src*_used and writes_rd come from package functions of the opcode.
  - A busy bit cleared by a same-cycle writeback to the same file/index does not count as a hazard.
- in_ready = ~hazard && (~out_valid || out_ready) && ~flush.
- Accept (in_valid && in_ready): next cycle the output registers hold opcode, offset, PC, register numbers and fmodes; out_valid=1. Latency is 1 cycle.
- Operand forwarding: if wb_valid && wb_fmode==fmodeN && wb_no==regN, rs/rt capture wb_data; otherwise they capture reg_out.
- Consume without accept: out_valid && out_ready && ~accept drops out_valid to 0. Outputs other than out_valid hold their values when not loading.
- Scoreboard: busy[2][NREG].
  - Accept with writes_rd sets busy[fmode_dest][rd].
  - wb_valid clears busy[wb_fmode][wb_no].
  - Set and clear of the same bit in the same cycle: set wins.
  - Integer r0 is never set busy.
- Flush:
  - out_valid goes to 0 next cycle; no accept that cycle.
  - Clears the busy bit set by the held instruction if it was not already consumed (tracked by a held_sets_busy flag plus held dest/fmode).
  - Set/clear precedence still applies to that bit.
- stall_cnt increments each cycle with hazard && ~flush; saturates at all-ones.
- Reset, synchronous, overrides everything:
  - opecode = INST_J; all other output registers 0; out_valid 0
  - scoreboard all clear; stall_cnt 0; held_sets_busy 0
  - Reset mid-operation discards the held instruction silently.

Decomposition:
- Shared package (existing instruction-set package): opcode constants (INST_J, ...), is_branch_inst, uses_src1, uses_src2, writes_rd, fmode helper functions.
- One sub-module: decode_scoreboard. It holds busy bits, set/clear/flush-undo precedence, and the combinational hazard lookup. The top holds field extraction, handshake, forwarding, output registers and counter.

Test Plan:
- Reset then single int ALU command, pc=0x100, reg_out1=5, reg_out2=7, out_ready=1 → next cycle out_valid=1, pc_out=0x100, rs=5, rt=7; opecode=INST_J during reset.
- Writer to r3 accepted, then reader of r3 offered with no writeback → in_ready=0 and stall_cnt increments each cycle. wb_valid, wb_no=3, wb_data=0x2A → accepted that same cycle, rs=0x2A.
- out_ready=0 with out_valid=1, new command offered → in_ready=0, outputs stable. Then out_ready=1 → accepted, back-to-back throughput 1/cycle.
- Float writer to f4 and int reader of r4 (fmode1=0) → no stall; same index in the other file is independent.
- Writer to r6 held, flush=1 → out_valid=0 next cycle, busy[0][6] cleared, a later reader of r6 is accepted without stall. Reset asserted while busy bits set → all clear.
- Writer to r0 accepted, reader of r0 next → no stall. Writer to r9 accepted in the same cycle wb clears r9 → busy[0][9]=1.
